itype_commit_checker: RTL and testbench
=======================================

Name: itype_commit_checker

Overview:
- Golden checker for the sodor5 I-type instruction stream.
- Decodes each I-type instruction fed to the core, executes it against a private shadow register file, and queues the expected {rd, data} write-back.
- Compares each queue entry, in order, against the core's commit port.
- Sits in sodor5_verif next to the core; self-contained consumer of the instruction encodings the bench produces.

Parameters:
- NUM_REGS, 32, architectural register count (rd/rs1 width = 5)
- WORD_SIZE, 32, data width
- EXP_DEPTH, 8, expected-result FIFO depth (power of 2)
- CNT_W, 16, width of commit and mismatch counters

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- init_we  in  1  shadow regfile write strobe (initial randomization)
- init_addr  in  5  shadow regfile write index
- init_data  in  WORD_SIZE  shadow regfile write data
- instr_valid  in  1  instr is issued to the core this cycle
- instr  in  32  instruction word
- wb_valid  in  1  core commits a register write this cycle
- wb_rd  in  5  committed destination
- wb_data  in  WORD_SIZE  committed value
- pending  out  $clog2(EXP_DEPTH)+1  expected entries outstanding
- commit_count  out  CNT_W  commits compared
- mismatch_count  out  CNT_W  failed compares
- error  out  1  sticky: any error seen
- err_code  out  3  first error cause, sticky

Behaviour:
Reset:
- All outputs are 0, FIFO empty, err_code = ERR_NONE.
- The shadow regfile is NOT reset; it is loaded only through init_*.
- Reset mid-operation discards all pending entries.

Decode:
- Applied when instr_valid = 1.
- opcode[6:0] must be 7'b0010011, otherwise ERR_ILLEGAL.
- funct3 = 1 requires imm[11:5] = 0, otherwise ERR_ILLEGAL.
- funct3 = 5 requires imm[11:5] in {0x00, 0x20}, otherwise ERR_ILLEGAL.
- An illegal word pushes nothing and does not update the shadow regfile.

Execute (combinational, same cycle):
- Source a = shadow[rs1], with x0 reading as 0. Immediate imm = sign-extended instr[31:20]. shamt = instr[24:20].
- ADDI: a + imm, mod 2^32.
- SLTI: signed compare. SLTIU: unsigned compare against the sign-extended imm.
- XORI / ORI / ANDI: bitwise.
- SLLI: a << shamt. SRLI: a >> shamt. SRAI: arithmetic right shift (instr[30] = 1).

Update:
- On the next clk edge, shadow[rd] <= result when rd != 0.
- {rd, result} is pushed to the FIFO for every legal instruction, including rd = 0.
- Back-to-back dependent instructions see the updated value because the write completes before the next read.

init port:
- init_we writes the shadow at the edge; writes to index 0 are ignored.
- If init_we and instr_valid both hit the same rd in one cycle, init wins.
- The instruction in that cycle reads the pre-edge value.

Compare:
- Applies when wb_valid = 1 and the FIFO is non-empty: pop the head and increment commit_count.
- A mismatch is wb_rd != exp_rd, or (exp_rd != 0 and wb_data != exp_data).
- wb_data is not compared when exp_rd = 0.
- On a mismatch: mismatch_count += 1 and error is set, with ERR_RD or ERR_DATA (ERR_RD takes precedence).

Boundaries:
- wb_valid with the FIFO empty: ERR_UNDERFLOW, nothing popped.
- There is no same-cycle bypass: an entry pushed in cycle N is poppable from N+1.
- Push when full with no pop in the same cycle: ERR_OVERFLOW, the entry is dropped.
- Simultaneous push and pop when full is legal.
- Counters saturate at all-ones.
- err_code latches the first error only. If two causes occur in one cycle, priority is OVERFLOW > UNDERFLOW > RD > DATA > ILLEGAL.

Decomposition:
- Package itype_chk_pkg holds:
  - OPC_OP_IMM.
  - F3_* constants: ADDI=0, SLLI=1, SLTI=2, SLTIU=3, XORI=4, SR=5, ORI=6, ANDI=7.
  - err_code enum: NONE=0, ILLEGAL=1, UNDERFLOW=2, OVERFLOW=3, RD=4, DATA=5.
  - The expected-entry struct {rd[4:0], data[WORD_SIZE-1:0]}.
- One sub-module, itype_exp_fifo: synchronous FIFO with async active-low reset, registered count, and full/empty flags; no bypass.

Test Plan:
- Pre-fill: init x5 = 0x00000010. Instr ADDI x7,x5,-1 (0xFFF28393); commit wb rd=7 data=0x0000000F four cycles later. Required: commit_count = 1, error = 0.
- SRAI x3,x5,4 (0x4042D193) with x5 = 0x80000000; commit rd=3 data 0x78000000 instead of 0xF8000000. Required: mismatch_count = 1, err_code = DATA.
- wb_valid with no prior instr. Required: err_code = UNDERFLOW, pending = 0.
- 9 legal instructions, no commits, EXP_DEPTH = 8. Required: 9th raises OVERFLOW, pending = 8.
- SLLI with imm[11:5] = 0x01 (0x02029193). Required: ILLEGAL, no push, shadow x3 unchanged.
- Assert reset_n low with 3 pending. Required: pending = 0 and error = 0 asynchronously; a subsequent commit reports UNDERFLOW.

Source files
------------

// File: rtl/itype_chk_pkg.sv
// Shared definitions for the I-type commit checker: opcode/funct3 encodings,
// error cause codes and the expected write-back entry carried through the FIFO.
// No logic; imported by the FIFO and the checker top.
package itype_chk_pkg;

   // Datapath width of the RV32 I-type stream; the expected entry is sized by it.
   localparam int XLEN = 32;

   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

   localparam logic [2:0] F3_ADDI  = 3'd0;
   localparam logic [2:0] F3_SLLI  = 3'd1;
   localparam logic [2:0] F3_SLTI  = 3'd2;
   localparam logic [2:0] F3_SLTIU = 3'd3;
   localparam logic [2:0] F3_XORI  = 3'd4;
   localparam logic [2:0] F3_SR    = 3'd5;
   localparam logic [2:0] F3_ORI   = 3'd6;
   localparam logic [2:0] F3_ANDI  = 3'd7;

   typedef enum logic [2:0] {
      ERR_NONE      = 3'd0,
      ERR_ILLEGAL   = 3'd1,
      ERR_UNDERFLOW = 3'd2,
      ERR_OVERFLOW  = 3'd3,
      ERR_RD        = 3'd4,
      ERR_DATA      = 3'd5
   } err_code_e;

   typedef struct packed {
      logic [4:0]      rd;
      logic [XLEN-1:0] data;
   } exp_entry_t;

   // Shift encodings constrain imm[11:5]; every other funct3 takes any immediate.
   function automatic logic funct7_legal(input logic [2:0] f3, input logic [6:0] f7);
      logic ok;
      ok = 1'b1;
      if (f3 == F3_SLLI) begin
         ok = (f7 == 7'h00);
      end else if (f3 == F3_SR) begin
         ok = (f7 == 7'h00) || (f7 == 7'h20);
      end
      return ok;
   endfunction

endpackage

// File: rtl/itype_exp_fifo.sv
// Expected-result FIFO: synchronous, registered count, full/empty flags.
// Latency: an entry pushed at edge N is visible at the head after that edge (no bypass).
// Backpressure: push while full is dropped unless a pop happens in the same cycle.
// Ports: push_vld/push_dat in, pop_vld in, head_dat/full/empty/count out.
module itype_exp_fifo #(
   parameter int WIDTH = 37,
   parameter int DEPTH = 8
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       push_vld,
   input  logic [WIDTH-1:0]           push_dat,
   input  logic                       pop_vld,
   output logic [WIDTH-1:0]           head_dat,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             do_push, do_pop;

   assign full     = (count_q == CW'(DEPTH));
   assign empty    = (count_q == '0);
   assign count    = count_q;
   assign head_dat = mem_q[rd_ptr_q];

   // Full-with-pop is legal: the write lands in the slot being vacated.
   assign do_push = push_vld && (!full || pop_vld);
   assign do_pop  = pop_vld && !empty;

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) begin
         mem_d[wr_ptr_q] = push_dat;
         wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (do_pop) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end
      if (do_push && !do_pop) begin
         count_d = count_q + CW'(1);
      end else if (!do_push && do_pop) begin
         count_d = count_q - CW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage is don't-care while empty, so it carries no reset.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

endmodule

// File: rtl/itype_commit_checker.sv
// Golden I-type checker: decodes/executes each issued instruction on a shadow
// regfile and compares queued {rd,data} results in order against core commits.
// Latency: result computed the issue cycle, poppable from the next cycle.
// Backpressure: none; overflow drops the entry, underflow pops nothing, both flagged.
// Ports: init_* loads shadow regs; instr_* issue stream; wb_* commit stream;
//        pending/commit_count/mismatch_count/error/err_code status.
module itype_commit_checker
   import itype_chk_pkg::*;
#(
   parameter int NUM_REGS  = 32,
   parameter int WORD_SIZE = XLEN,   // must equal XLEN: the FIFO entry is sized by it
   parameter int EXP_DEPTH = 8,
   parameter int CNT_W     = 16
) (
   input  logic                        clk,
   input  logic                        reset_n,
   input  logic                        init_we,
   input  logic [4:0]                  init_addr,
   input  logic [WORD_SIZE-1:0]        init_data,
   input  logic                        instr_valid,
   input  logic [31:0]                 instr,
   input  logic                        wb_valid,
   input  logic [4:0]                  wb_rd,
   input  logic [WORD_SIZE-1:0]        wb_data,
   output logic [$clog2(EXP_DEPTH):0]  pending,
   output logic [CNT_W-1:0]            commit_count,
   output logic [CNT_W-1:0]            mismatch_count,
   output logic                        error,
   output logic [2:0]                  err_code
);

   // ---------------- decode ----------------
   logic [6:0]           opcode, funct7;
   logic [2:0]           funct3;
   logic [4:0]           rd, rs1, shamt;
   logic [WORD_SIZE-1:0] imm, src_a, result;
   logic                 legal, exec_vld, illegal_evt;

   assign opcode = instr[6:0];
   assign rd     = instr[11:7];
   assign funct3 = instr[14:12];
   assign rs1    = instr[19:15];
   assign shamt  = instr[24:20];
   assign funct7 = instr[31:25];
   assign imm    = {{(WORD_SIZE-12){instr[31]}}, instr[31:20]};

   assign legal       = (opcode == OPC_OP_IMM) && funct7_legal(funct3, funct7);
   assign exec_vld    = instr_valid && legal;
   assign illegal_evt = instr_valid && !legal;

   // ---------------- shadow regfile ----------------
   logic [WORD_SIZE-1:0] shadow_q [NUM_REGS];
   logic [WORD_SIZE-1:0] shadow_d [NUM_REGS];

   assign src_a = (rs1 == 5'd0) ? '0 : shadow_q[rs1];

   // ---------------- execute ----------------
   always_comb begin
      result = '0;
      case (funct3)
         F3_ADDI:  result = src_a + imm;
         F3_SLTI:  result[0] = ($signed(src_a) < $signed(imm));
         F3_SLTIU: result[0] = (src_a < imm);
         F3_XORI:  result = src_a ^ imm;
         F3_ORI:   result = src_a | imm;
         F3_ANDI:  result = src_a & imm;
         F3_SLLI:  result = src_a << shamt;
         F3_SR: begin
            if (instr[30]) result = $signed(src_a) >>> shamt;
            else           result = src_a >> shamt;
         end
         default:  result = '0;
      endcase
   end

   // The instruction reads pre-edge state; the init write is applied last so it
   // wins when both target the same register.
   always_comb begin
      shadow_d = shadow_q;
      if (exec_vld && (rd != 5'd0)) begin
         shadow_d[rd] = result;
      end
      if (init_we && (init_addr != 5'd0)) begin
         shadow_d[init_addr] = init_data;
      end
   end

   // Architectural state is loaded only through init_*, never by reset.
   always_ff @(posedge clk) begin
      shadow_q <= shadow_d;
   end

   // ---------------- expected FIFO ----------------
   exp_entry_t push_dat, head;
   logic       fifo_full, fifo_empty, push_vld, pop_vld;

   assign push_dat = '{rd: rd, data: result};
   assign pop_vld  = wb_valid && !fifo_empty;
   assign push_vld = exec_vld && (!fifo_full || pop_vld);

   itype_exp_fifo #(
      .WIDTH ($bits(exp_entry_t)),
      .DEPTH (EXP_DEPTH)
   ) u_exp_fifo (
      .clk      (clk),
      .rst_n    (reset_n),
      .push_vld (push_vld),
      .push_dat (push_dat),
      .pop_vld  (pop_vld),
      .head_dat (head),
      .full     (fifo_full),
      .empty    (fifo_empty),
      .count    (pending)
   );

   // ---------------- compare ----------------
   logic rd_mis, data_mis, underflow_evt, overflow_evt;

   assign underflow_evt = wb_valid && fifo_empty;
   assign overflow_evt  = exec_vld && fifo_full && !pop_vld;
   assign rd_mis        = pop_vld && (wb_rd != head.rd);
   // x0 results are architecturally discarded, so their data is never checked.
   assign data_mis      = pop_vld && (head.rd != 5'd0) && (wb_data != head.data);

   logic [CNT_W-1:0] commit_count_q, commit_count_d;
   logic [CNT_W-1:0] mismatch_count_q, mismatch_count_d;
   logic             error_q, error_d;
   err_code_e        err_code_q, err_code_d, evt_code;

   always_comb begin
      commit_count_d   = commit_count_q;
      mismatch_count_d = mismatch_count_q;
      evt_code         = ERR_NONE;

      if (pop_vld && (commit_count_q != '1)) begin
         commit_count_d = commit_count_q + CNT_W'(1);
      end
      if ((rd_mis || data_mis) && (mismatch_count_q != '1)) begin
         mismatch_count_d = mismatch_count_q + CNT_W'(1);
      end

      if (overflow_evt)       evt_code = ERR_OVERFLOW;
      else if (underflow_evt) evt_code = ERR_UNDERFLOW;
      else if (rd_mis)        evt_code = ERR_RD;
      else if (data_mis)      evt_code = ERR_DATA;
      else if (illegal_evt)   evt_code = ERR_ILLEGAL;

      error_d    = error_q || (evt_code != ERR_NONE);
      err_code_d = (err_code_q == ERR_NONE) ? evt_code : err_code_q;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         commit_count_q   <= '0;
         mismatch_count_q <= '0;
         error_q          <= 1'b0;
         err_code_q       <= ERR_NONE;
      end else begin
         commit_count_q   <= commit_count_d;
         mismatch_count_q <= mismatch_count_d;
         error_q          <= error_d;
         err_code_q       <= err_code_d;
      end
   end

   assign commit_count   = commit_count_q;
   assign mismatch_count = mismatch_count_q;
   assign error          = error_q;
   assign err_code       = err_code_q;

endmodule

// File: tb/tb_itype_commit_checker.sv
module tb_itype_commit_checker;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        init_we;
   logic [4:0]  init_addr;
   logic [31:0] init_data;
   logic        instr_valid;
   logic [31:0] instr;
   logic        wb_valid;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;
   logic [3:0]  pending;
   logic [4:0]  commit_count;
   logic [4:0]  mismatch_count;
   logic        error;
   logic [2:0]  err_code;

   int checks = 0;
   int errors = 0;

   // Narrow counters so saturation is reachable in a short run.
   itype_commit_checker #(
      .NUM_REGS (32), .WORD_SIZE (32), .EXP_DEPTH (8), .CNT_W (5)
   ) dut (
      .clk (clk), .reset_n (reset_n),
      .init_we (init_we), .init_addr (init_addr), .init_data (init_data),
      .instr_valid (instr_valid), .instr (instr),
      .wb_valid (wb_valid), .wb_rd (wb_rd), .wb_data (wb_data),
      .pending (pending), .commit_count (commit_count),
      .mismatch_count (mismatch_count), .error (error), .err_code (err_code)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [4:0]  init_addr;
      logic [31:0] init_data;
      logic [31:0] instr;
      logic [4:0]  wb_rd;
      logic [31:0] wb_data;
   } vec_t;

   vec_t vecs [14];

   function automatic logic [31:0] enc(input logic [11:0] imm, input logic [4:0] rs1,
                                       input logic [2:0] f3, input logic [4:0] rd);
      return {imm, rs1, f3, rd, 7'b0010011};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic idle();
      init_we = 1'b0; init_addr = '0; init_data = '0;
      instr_valid = 1'b0; instr = '0;
      wb_valid = 1'b0; wb_rd = '0; wb_data = '0;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      idle();
   endtask

   task automatic do_reset();
      idle();
      reset_n = 1'b0;
      @(posedge clk);
      #1;
      reset_n = 1'b1;
   endtask

   task automatic issue(input logic [31:0] w);
      instr_valid = 1'b1; instr = w;
   endtask

   task automatic commit(input logic [4:0] r, input logic [31:0] d);
      wb_valid = 1'b1; wb_rd = r; wb_data = d;
   endtask

   task automatic init(input logic [4:0] a, input logic [31:0] d);
      init_we = 1'b1; init_addr = a; init_data = d;
   endtask

   logic [4:0]  exp_rd [6];
   logic [31:0] exp_dat [6];

   initial begin
      vecs[0]  = '{5'd5, 32'h00000010, 32'hFFF28393,               5'd7,  32'h0000000F};
      vecs[1]  = '{5'd5, 32'hFFFFFFFF, enc(12'h7FF, 5'd5, 3'd0, 5'd8),  5'd8,  32'h000007FE};
      vecs[2]  = '{5'd5, 32'hFFFFFFFE, enc(12'hFFF, 5'd5, 3'd2, 5'd9),  5'd9,  32'h00000001};
      vecs[3]  = '{5'd5, 32'h00000001, enc(12'hFFF, 5'd5, 3'd2, 5'd9),  5'd9,  32'h00000000};
      vecs[4]  = '{5'd5, 32'h80000000, enc(12'hFFF, 5'd5, 3'd3, 5'd10), 5'd10, 32'h00000001};
      vecs[5]  = '{5'd5, 32'h00000005, enc(12'h001, 5'd5, 3'd3, 5'd10), 5'd10, 32'h00000000};
      vecs[6]  = '{5'd5, 32'h12345678, enc(12'h0F0, 5'd5, 3'd4, 5'd11), 5'd11, 32'h12345688};
      vecs[7]  = '{5'd5, 32'h00000123, enc(12'h800, 5'd5, 3'd6, 5'd12), 5'd12, 32'hFFFFF923};
      vecs[8]  = '{5'd5, 32'hDEADBEEF, enc(12'h0FF, 5'd5, 3'd7, 5'd13), 5'd13, 32'h000000EF};
      vecs[9]  = '{5'd5, 32'h00000003, enc(12'h01F, 5'd5, 3'd1, 5'd14), 5'd14, 32'h80000000};
      vecs[10] = '{5'd5, 32'h80000000, enc(12'h004, 5'd5, 3'd5, 5'd15), 5'd15, 32'h08000000};
      vecs[11] = '{5'd5, 32'h80000000, 32'h4042D193,               5'd3,  32'hF8000000};
      // rd = x0: data is not compared, so a junk value must still pass.
      vecs[12] = '{5'd5, 32'h00000001, enc(12'h005, 5'd5, 3'd0, 5'd0),  5'd0,  32'h00000BAD};
      // x0 source reads zero; the init write to x0 is ignored.
      vecs[13] = '{5'd0, 32'h00000055, enc(12'hFFB, 5'd0, 3'd0, 5'd16), 5'd16, 32'hFFFFFFFB};

      idle();
      reset_n = 1'b0;
      @(posedge clk);
      #1;
      chk("rst_pending", 32'(pending), 0);
      chk("rst_commit", 32'(commit_count), 0);
      chk("rst_mismatch", 32'(mismatch_count), 0);
      chk("rst_error", 32'(error), 0);
      chk("rst_err_code", 32'(err_code), 0);
      reset_n = 1'b1;

      // ---- table: one init, one issue, one matching commit per vector ----
      for (int i = 0; i < 14; i++) begin
         init(vecs[i].init_addr, vecs[i].init_data);
         step();
         issue(vecs[i].instr);
         step();
         chk($sformatf("v%0d_pending", i), 32'(pending), 1);
         commit(vecs[i].wb_rd, vecs[i].wb_data);
         step();
         chk($sformatf("v%0d_commit", i), 32'(commit_count), 32'(i + 1));
         chk($sformatf("v%0d_mismatch", i), 32'(mismatch_count), 0);
         chk($sformatf("v%0d_error", i), 32'(error), 0);
      end

      // ---- dependent issue, init-wins, pre-edge read ----
      init(5'd5, 32'h10);                                   step();
      issue(enc(12'h001, 5'd5, 3'd0, 5'd6));                step();
      issue(enc(12'h001, 5'd6, 3'd0, 5'd6));                step();
      init(5'd20, 32'h100); issue(enc(12'h001, 5'd5, 3'd0, 5'd20)); step();
      init(5'd5, 32'h999);  issue(enc(12'h000, 5'd5, 3'd0, 5'd22)); step();
      issue(enc(12'h000, 5'd20, 3'd0, 5'd21));              step();
      issue(enc(12'h000, 5'd5, 3'd0, 5'd23));               step();
      chk("dep_pending", 32'(pending), 6);
      exp_rd  = '{5'd6, 5'd6, 5'd20, 5'd22, 5'd21, 5'd23};
      exp_dat = '{32'h11, 32'h12, 32'h11, 32'h10, 32'h100, 32'h999};
      for (int i = 0; i < 6; i++) begin
         commit(exp_rd[i], exp_dat[i]);
         step();
      end
      chk("dep_commit", 32'(commit_count), 20);
      chk("dep_mismatch", 32'(mismatch_count), 0);
      chk("dep_error", 32'(error), 0);

      // ---- data mismatch on SRAI ----
      do_reset();
      init(5'd5, 32'h80000000);  step();
      issue(32'h4042D193);       step();
      commit(5'd3, 32'h78000000); step();
      chk("data_mismatch", 32'(mismatch_count), 1);
      chk("data_err_code", 32'(err_code), 5);
      chk("data_error", 32'(error), 1);
      chk("data_commit", 32'(commit_count), 1);

      // ---- rd mismatch beats data mismatch and a same-cycle illegal ----
      do_reset();
      init(5'd5, 32'h10);        step();
      issue(32'hFFF28393);       step();
      commit(5'd8, 32'h1234); issue(32'h00000033); step();
      chk("rd_err_code", 32'(err_code), 4);
      chk("rd_mismatch", 32'(mismatch_count), 1);
      chk("rd_pending", 32'(pending), 0);

      // ---- underflow, then no same-cycle bypass ----
      do_reset();
      commit(5'd1, 32'h0);       step();
      chk("uf_err_code", 32'(err_code), 2);
      chk("uf_pending", 32'(pending), 0);
      chk("uf_commit", 32'(commit_count), 0);
      issue(enc(12'h003, 5'd0, 3'd0, 5'd1)); commit(5'd1, 32'h3); step();
      chk("nobyp_pending", 32'(pending), 1);
      chk("nobyp_commit", 32'(commit_count), 0);
      commit(5'd1, 32'h3);       step();
      chk("nobyp_commit2", 32'(commit_count), 1);
      chk("nobyp_mismatch", 32'(mismatch_count), 0);

      // ---- underflow outranks illegal in the same cycle ----
      do_reset();
      commit(5'd1, 32'h0); issue(32'h02029193); step();
      chk("uf_vs_ill", 32'(err_code), 2);

      // ---- overflow, full push+pop, drain ----
      do_reset();
      for (int k = 1; k <= 9; k++) begin
         issue(enc(12'(k), 5'd0, 3'd0, 5'd1));
         step();
         if (k == 8) begin
            chk("full_pending", 32'(pending), 8);
            chk("full_error", 32'(error), 0);
         end
      end
      chk("ovf_err_code", 32'(err_code), 3);
      chk("ovf_pending", 32'(pending), 8);
      issue(enc(12'd10, 5'd0, 3'd0, 5'd1)); commit(5'd1, 32'd1); step();
      chk("fullpp_pending", 32'(pending), 8);
      chk("fullpp_commit", 32'(commit_count), 1);
      for (int k = 2; k <= 8; k++) begin
         commit(5'd1, 32'(k));
         step();
      end
      commit(5'd1, 32'd10);      step();
      chk("drain_commit", 32'(commit_count), 9);
      chk("drain_mismatch", 32'(mismatch_count), 0);
      chk("drain_pending", 32'(pending), 0);

      // ---- illegal encodings leave FIFO and shadow untouched ----
      do_reset();
      init(5'd3, 32'hABCD);      step();
      issue(32'h02029193);       step();
      chk("ill_err_code", 32'(err_code), 1);
      chk("ill_pending", 32'(pending), 0);
      chk("ill_error", 32'(error), 1);
      issue(enc(12'h204, 5'd5, 3'd5, 5'd3)); step();
      chk("ill_sr_pending", 32'(pending), 0);
      issue(enc(12'h000, 5'd3, 3'd0, 5'd4)); step();
      commit(5'd4, 32'hABCD);    step();
      chk("ill_x3_commit", 32'(commit_count), 1);
      chk("ill_x3_mismatch", 32'(mismatch_count), 0);

      // ---- asynchronous reset with entries outstanding ----
      do_reset();
      issue(enc(12'h001, 5'd0, 3'd0, 5'd1)); commit(5'd1, 32'h1); step();
      issue(enc(12'h002, 5'd0, 3'd0, 5'd1)); step();
      issue(enc(12'h003, 5'd0, 3'd0, 5'd1)); step();
      chk("mid_pending", 32'(pending), 3);
      chk("mid_error", 32'(error), 1);
      #2 reset_n = 1'b0;
      #1;
      chk("arst_pending", 32'(pending), 0);
      chk("arst_error", 32'(error), 0);
      chk("arst_err_code", 32'(err_code), 0);
      @(negedge clk);
      reset_n = 1'b1;
      commit(5'd1, 32'h2);       step();
      chk("post_rst_uf", 32'(err_code), 2);
      chk("post_rst_commit", 32'(commit_count), 0);

      // ---- counter saturation ----
      do_reset();
      issue(enc(12'h001, 5'd0, 3'd0, 5'd1)); step();
      for (int k = 0; k < 34; k++) begin
         issue(enc(12'h001, 5'd0, 3'd0, 5'd1));
         commit(5'd2, 32'h0);
         step();
      end
      commit(5'd2, 32'h0);       step();
      chk("sat_commit", 32'(commit_count), 31);
      chk("sat_mismatch", 32'(mismatch_count), 31);
      chk("sat_pending", 32'(pending), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
